hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
Parametrised hazard and forwarding unit for the pipelined RISC-V core. It replaces the fixed three-deep forwarding logic with a DEPTH-slot shift register that tracks in-flight writers behind decode. Each cycle it resolves rs1/rs2 operands against those writers, issues load-use stalls, and honours branch flushes. It sits in decode, between the register file read and the id_ex register, and also keeps saturating hazard statistics.

Parameters:
XLEN, 32, operand data width
DEPTH, 3, tracked slots behind decode (slot 1 = EX ... slot DEPTH = WB)
LOAD_READY, 3, first slot whose stage_val holds valid load data; must be 2..DEPTH
CNT_W, 32, statistics counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
issue_valid  in  1  decode holds a real instruction this cycle
issue_wb_en  in  1  issuing instruction writes rd
issue_from_mem  in  1  issuing instruction is a load
issue_rd_addr  in  5  issuing destination register
rs1_addr  in  5  decode source register 1
rs2_addr  in  5  decode source register 2
use_rs1  in  1  rs1 is read
use_rs2  in  1  rs2 is read
rs1_reg  in  XLEN  register-file value for rs1
rs2_reg  in  XLEN  register-file value for rs2
stage_val  in  DEPTH*XLEN  result held in slot k, at bits [k*XLEN-1 -: XLEN]
flush  in  1  kill the instruction in slot 1 and the instruction in decode
stall  out  1  hold pc and if_id; insert a bubble into id_ex
rs1_val  out  XLEN  resolved rs1 value
rs2_val  out  XLEN  resolved rs2 value
rs1_late  out  1  rs1 comes from the slot-1 result; EX muxes in its own ALU output
rs2_late  out  1  same, for rs2
stall_count  out  CNT_W  cycles in which stall was asserted
fwd_count  out  CNT_W  operands resolved from a slot other than the register file

Behaviour:
- State: per slot k, valid / wb_en / from_mem / rd_addr. Reset clears all valid bits and zeroes both counters.
- Shift every cycle: slot k+1 <= slot k, and slot DEPTH is dropped. Slot 1 <= the issuing instruction when issue_valid && !stall && !flush; otherwise slot 1 <= bubble (valid=0).
- flush: clears slot 1 at the same edge, so slot 2 <= bubble. Older slots shift normally. flush takes priority over stall.
- Match on slot k: valid && wb_en && rd_addr == rsN_addr && rsN_addr != 0 && use_rsN.
- Priority: the youngest match (lowest k) wins.
- No match: rsN_val = rsN_reg and rsN_late = 0. Reads of x0 always take this path.
- Match at slot 1, non-load: rsN_late = 1 and rsN_val = don't-care (drive 0).
- Match at slot k >= 2, non-load: rsN_val = stage_val slot k, late = 0.
- Match is a load at k < LOAD_READY: hazard, stall = 1. rsN_val and late are don't-care.
- Match is a load at k >= LOAD_READY: rsN_val = stage_val slot k.
- stall = issue_valid && !flush && (a hazard on rs1 or on rs2). All outputs are combinational from state and inputs; zero added latency.
- Stall duration: one bubble per missing slot, LOAD_READY-k cycles. The default is 2 cycles for a back-to-back load-use.
- Counters:
  - stall_count += 1 in each cycle with stall.
  - fwd_count += (rs1 forwarded or late) + (rs2 forwarded or late), counted only in cycles with no stall and no flush.
  - Both counters saturate at all-ones.
- Reset mid-stream: the next cycle has all slots empty, so stall = 0 and all operands come from the register file.

Test Plan:
- Reset, then issue x5=... (ALU) followed by a read of x5 next cycle -> rs1_late=1, stall=0. Two cycles later a read of x5 -> rs1_val = stage_val slot 2, rs1_late=0.
- Load x6 followed immediately by add reading x6 -> stall=1 for 2 cycles, stall_count=2. Third cycle -> rs1_val = stage_val slot 3 = 0xDEADBEEF.
- Slot 1 and slot 3 both write x7 (values 0x11 and 0x33) -> rs2_late=1, i.e. the youngest wins. Same setup with rs2_addr=0 -> rs2_val = rs2_reg, fwd_count unchanged.
- Load x8 in slot 1 with flush asserted and a dependent read in decode -> stall=0. Next cycle slot 2 is a bubble, and a read of x8 returns rs1_reg.
- DEPTH=5, LOAD_READY=4: load followed immediately by a dependent instruction -> stall for 3 cycles. A dependency at distance 5 -> stage_val slot 5. A dependency at distance 6 -> rs1_reg.
- CNT_W=4 with 20 stall cycles -> stall_count holds at 15. rst asserted mid-stall -> stall=0 and counters=0 on the next cycle.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - decode-side bus between the core and the hazard scoreboard
interface hazard_scoreboard_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 3,
  parameter int CNT_W = 32
);
  logic                  issue_valid;
  logic                  issue_wb_en;
  logic                  issue_from_mem;
  logic [4:0]            issue_rd_addr;
  logic [4:0]            rs1_addr;
  logic [4:0]            rs2_addr;
  logic                  use_rs1;
  logic                  use_rs2;
  logic [XLEN-1:0]       rs1_reg;
  logic [XLEN-1:0]       rs2_reg;
  logic [DEPTH*XLEN-1:0] stage_val;
  logic                  flush;
  logic                  stall;
  logic [XLEN-1:0]       rs1_val;
  logic [XLEN-1:0]       rs2_val;
  logic                  rs1_late;
  logic                  rs2_late;
  logic [CNT_W-1:0]      stall_count;
  logic [CNT_W-1:0]      fwd_count;

  modport master (
    output issue_valid, issue_wb_en, issue_from_mem, issue_rd_addr,
    output rs1_addr, rs2_addr, use_rs1, use_rs2, rs1_reg, rs2_reg,
    output stage_val, flush,
    input  stall, rs1_val, rs2_val, rs1_late, rs2_late, stall_count, fwd_count
  );

  modport slave (
    input  issue_valid, issue_wb_en, issue_from_mem, issue_rd_addr,
    input  rs1_addr, rs2_addr, use_rs1, use_rs2, rs1_reg, rs2_reg,
    input  stage_val, flush,
    output stall, rs1_val, rs2_val, rs1_late, rs2_late, stall_count, fwd_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - DEPTH-slot writer tracker resolving rs1/rs2 forwarding and load-use stalls
module hazard_scoreboard #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 3,
  parameter int CNT_W      = 32
) (
  input logic              clk,
  input logic              rst,
  hazard_scoreboard_if.slave bus
);

  logic [DEPTH:1]  slot_valid;
  logic [DEPTH:1]  slot_wb;
  logic [DEPTH:1]  slot_mem;
  logic [4:0]      slot_rd [1:DEPTH];

  logic [4:0]      op_addr [2];
  logic            op_use  [2];
  logic [XLEN-1:0] op_reg  [2];
  logic [XLEN-1:0] op_val  [2];
  logic            op_late [2];
  logic            op_fwd  [2];
  logic            op_haz  [2];

  logic            hit;
  logic            hit_mem;
  int              hit_k;
  logic [XLEN-1:0] hit_val;

  logic            stall;
  logic [1:0]      fwd_inc;
  logic [CNT_W:0]  fwd_sum;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] fwd_cnt;

  assign op_addr[0] = bus.rs1_addr;
  assign op_addr[1] = bus.rs2_addr;
  assign op_use[0]  = bus.use_rs1;
  assign op_use[1]  = bus.use_rs2;
  assign op_reg[0]  = bus.rs1_reg;
  assign op_reg[1]  = bus.rs2_reg;

  // Scan oldest to youngest so the lowest-numbered matching slot is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_mem = 1'b0;
    hit_k   = 0;
    hit_val = '0;
    for (int n = 0; n < 2; n++) begin
      op_val[n]  = '0;
      op_late[n] = 1'b0;
      op_fwd[n]  = 1'b0;
      op_haz[n]  = 1'b0;
      hit        = 1'b0;
      hit_mem    = 1'b0;
      hit_k      = 0;
      hit_val    = '0;
      for (int k = DEPTH; k >= 1; k--) begin
        if (slot_valid[k] && slot_wb[k] && slot_rd[k] == op_addr[n] &&
            op_addr[n] != 5'd0 && op_use[n]) begin
          hit     = 1'b1;
          hit_mem = slot_mem[k];
          hit_k   = k;
          hit_val = bus.stage_val[k*XLEN-1 -: XLEN];
        end
      end
      if (!hit) begin
        op_val[n] = op_reg[n];
      end else if (hit_mem && hit_k < LOAD_READY) begin
        op_haz[n] = 1'b1;
      end else if (!hit_mem && hit_k == 1) begin
        op_late[n] = 1'b1;
      end else begin
        op_fwd[n] = 1'b1;
        op_val[n] = hit_val;
      end
    end
  end

  assign stall   = bus.issue_valid && !bus.flush && (op_haz[0] || op_haz[1]);
  assign fwd_inc = 2'(op_fwd[0] | op_late[0]) + 2'(op_fwd[1] | op_late[1]);
  assign fwd_sum = {1'b0, fwd_cnt} + (CNT_W+1)'(fwd_inc);

  // A flush kills both the decode instruction and the one entering slot 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid <= '0;
      stall_cnt  <= '0;
      fwd_cnt    <= '0;
    end else begin
      slot_valid[1] <= bus.issue_valid && !stall && !bus.flush;
      slot_valid[2] <= slot_valid[1] && !bus.flush;
      for (int k = 3; k <= DEPTH; k++) begin
        slot_valid[k] <= slot_valid[k-1];
      end
      if (stall && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (!stall && !bus.flush) begin
        fwd_cnt <= fwd_sum[CNT_W] ? '1 : fwd_sum[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    slot_wb[1]  <= bus.issue_wb_en;
    slot_mem[1] <= bus.issue_from_mem;
    slot_rd[1]  <= bus.issue_rd_addr;
    for (int k = 2; k <= DEPTH; k++) begin
      slot_wb[k]  <= slot_wb[k-1];
      slot_mem[k] <= slot_mem[k-1];
      slot_rd[k]  <= slot_rd[k-1];
    end
  end

  assign bus.stall       = stall;
  assign bus.rs1_val     = op_val[0];
  assign bus.rs2_val     = op_val[1];
  assign bus.rs1_late    = op_late[0];
  assign bus.rs2_late    = op_late[1];
  assign bus.stall_count = stall_cnt;
  assign bus.fwd_count   = fwd_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - scoreboard bench for hazard_scoreboard (default and DEPTH=5/CNT_W=4 builds)
module tb_hazard_scoreboard;

  localparam logic [31:0] RS1 = 32'h1111_0001;
  localparam logic [31:0] RS2 = 32'h2222_0002;
  localparam logic [2:0]  K_ST = 3'd0, K_R1 = 3'd1, K_R2 = 3'd2, K_CNT = 3'd3, K_SC = 3'd4;

  typedef struct packed {
    logic [2:0]  kind;
    logic        dut;
    logic [31:0] v1;
    logic [31:0] v2;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passes = 0;

  exp_t  exp_q [$];
  string name_q [$];
  exp_t  e;
  string nm;

  logic [95:0]  sa;
  logic [159:0] sb;

  hazard_scoreboard_if #(.XLEN(32), .DEPTH(3), .CNT_W(32)) ia ();
  hazard_scoreboard_if #(.XLEN(32), .DEPTH(5), .CNT_W(4))  ib ();

  hazard_scoreboard #(.XLEN(32), .DEPTH(3), .LOAD_READY(3), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .bus(ia)
  );
  hazard_scoreboard #(.XLEN(32), .DEPTH(5), .LOAD_READY(4), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .bus(ib)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string n, input logic [2:0] k, input logic d,
                      input logic [31:0] v1, input logic [31:0] v2);
    exp_t x;
    x.kind = k;
    x.dut  = d;
    x.v1   = v1;
    x.v2   = v2;
    exp_q.push_back(x);
    name_q.push_back(n);
  endtask

  task automatic drive_a(input logic v, input logic wb, input logic mem, input logic [4:0] rd,
                         input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                         input logic u2, input logic fl);
    ia.issue_valid = v;  ia.issue_wb_en = wb; ia.issue_from_mem = mem; ia.issue_rd_addr = rd;
    ia.rs1_addr = r1;    ia.use_rs1 = u1;     ia.rs2_addr = r2;        ia.use_rs2 = u2;
    ia.flush = fl;
  endtask

  task automatic drive_b(input logic v, input logic wb, input logic mem, input logic [4:0] rd,
                         input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                         input logic u2, input logic fl);
    ib.issue_valid = v;  ib.issue_wb_en = wb; ib.issue_from_mem = mem; ib.issue_rd_addr = rd;
    ib.rs1_addr = r1;    ib.use_rs1 = u1;     ib.rs2_addr = r2;        ib.use_rs2 = u2;
    ib.flush = fl;
  endtask

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) $display("FAIL %s: got %h, expected %h", n, act, want);
    else passes++;
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      case (e.kind)
        K_ST:  check({nm, " stall"}, 32'(e.dut ? ib.stall : ia.stall), e.v1);
        K_R1: begin
          check({nm, " rs1_val"},  e.dut ? ib.rs1_val : ia.rs1_val, e.v1);
          check({nm, " rs1_late"}, 32'(e.dut ? ib.rs1_late : ia.rs1_late), e.v2);
        end
        K_R2: begin
          check({nm, " rs2_val"},  e.dut ? ib.rs2_val : ia.rs2_val, e.v1);
          check({nm, " rs2_late"}, 32'(e.dut ? ib.rs2_late : ia.rs2_late), e.v2);
        end
        K_CNT: begin
          check({nm, " stall_count"}, e.dut ? 32'(ib.stall_count) : ia.stall_count, e.v1);
          check({nm, " fwd_count"},   e.dut ? 32'(ib.fwd_count)   : ia.fwd_count,   e.v2);
        end
        default: check({nm, " stall_count"}, e.dut ? 32'(ib.stall_count) : ia.stall_count, e.v1);
      endcase
    end
  end

  initial begin
    sa = {32'hC3C3_C3C3, 32'hB2B2_B2B2, 32'hA1A1_A1A1};
    sb = {32'hE5E5_E5E5, 32'hD4D4_D4D4, 32'hC3C3_C3C3, 32'hB2B2_B2B2, 32'hA1A1_A1A1};
    ia.rs1_reg = RS1; ia.rs2_reg = RS2; ia.stage_val = sa;
    ib.rs1_reg = RS1; ib.rs2_reg = RS2; ib.stage_val = sb;
    drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // ALU writer of x5 then readers at distance 1 and 2
    drive_a(1, 1, 0, 5, 5, 1, 0, 0, 0);
    push("reset_r1", K_R1, 0, RS1, 0);
    push("reset", K_ST, 0, 0, 0);
    push("reset_cnt", K_CNT, 0, 0, 0);
    tick();
    drive_a(1, 0, 0, 0, 5, 1, 0, 0, 0);
    push("alu_d1", K_R1, 0, 0, 1);
    push("alu_d1", K_ST, 0, 0, 0);
    tick();
    push("alu_d2", K_R1, 0, 32'hB2B2_B2B2, 0);
    push("alu_d2_cnt", K_CNT, 0, 0, 1);
    tick();
    drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
    push("idle_cnt", K_CNT, 0, 0, 2);
    tick();

    // load x6 then dependent add: two stall cycles, then slot 3 data
    drive_a(1, 1, 1, 6, 0, 0, 0, 0, 0);
    tick();
    drive_a(1, 1, 0, 10, 6, 1, 0, 0, 0);
    push("lu_stall1", K_ST, 0, 1, 0);
    tick();
    push("lu_stall2", K_ST, 0, 1, 0);
    push("lu_stall2_cnt", K_CNT, 0, 1, 2);
    tick();
    ia.stage_val = {32'hDEAD_BEEF, 32'hB2B2_B2B2, 32'hA1A1_A1A1};
    push("lu_slot3", K_R1, 0, 32'hDEAD_BEEF, 0);
    push("lu_release", K_ST, 0, 0, 0);
    push("lu_release_cnt", K_CNT, 0, 2, 2);
    tick();
    ia.stage_val = sa;

    // x7 written from slot 1 and slot 3; youngest wins; x0 never forwards
    drive_a(1, 1, 0, 7, 0, 0, 0, 0, 0);
    push("x7_cnt", K_CNT, 0, 2, 3);
    tick();
    drive_a(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive_a(1, 1, 0, 7, 0, 0, 0, 0, 0);
    tick();
    ia.stage_val = {32'h0000_0033, 32'hB2B2_B2B2, 32'h0000_0011};
    drive_a(1, 1, 0, 0, 0, 0, 7, 1, 0);
    push("youngest", K_R2, 0, 0, 1);
    tick();
    ia.stage_val = sa;
    drive_a(1, 0, 0, 0, 0, 0, 0, 1, 0);
    push("x0_read", K_R2, 0, RS2, 0);
    push("x0_cnt", K_CNT, 0, 2, 4);
    tick();

    // flush of a load in slot 1 with a dependent read in decode
    drive_a(1, 1, 1, 8, 0, 0, 0, 0, 0);
    push("pre_flush_cnt", K_CNT, 0, 2, 4);
    tick();
    drive_a(1, 0, 0, 0, 8, 1, 0, 0, 1);
    push("flush", K_ST, 0, 0, 0);
    tick();
    drive_a(1, 0, 0, 0, 8, 1, 0, 0, 0);
    push("post_flush", K_R1, 0, RS1, 0);
    push("post_flush", K_ST, 0, 0, 0);
    tick();
    drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
    push("post_flush_cnt", K_CNT, 0, 2, 4);
    tick();

    // DEPTH=5, LOAD_READY=4: three-cycle load-use, distance 5 and 6
    drive_b(1, 1, 1, 9, 0, 0, 0, 0, 0);
    push("b_start_cnt", K_CNT, 1, 0, 0);
    tick();
    drive_b(1, 0, 0, 0, 9, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      push("b_lu_stall", K_ST, 1, 1, 0);
      tick();
    end
    push("b_slot4", K_R1, 1, 32'hD4D4_D4D4, 0);
    push("b_release", K_ST, 1, 0, 0);
    push("b_release_cnt", K_CNT, 1, 3, 0);
    tick();
    drive_b(1, 1, 0, 12, 0, 0, 0, 0, 0);
    tick();
    drive_b(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) tick();
    drive_b(1, 0, 0, 0, 12, 1, 0, 0, 0);
    push("b_dist5", K_R1, 1, 32'hE5E5_E5E5, 0);
    tick();
    push("b_dist6", K_R1, 1, RS1, 0);
    tick();

    // stall_count saturation at 15 with a 4-bit counter
    for (int i = 1; i <= 6; i++) begin
      drive_b(1, 1, 1, 9, 0, 0, 0, 0, 0);
      tick();
      drive_b(1, 0, 0, 0, 9, 1, 0, 0, 0);
      repeat (3) tick();
      push("b_sat", K_SC, 1, (3 + 3 * i > 15) ? 32'd15 : 32'(3 + 3 * i), 0);
      tick();
    end

    // reset in the middle of a load-use stall
    drive_b(1, 1, 1, 9, 0, 0, 0, 0, 0);
    tick();
    drive_b(1, 0, 0, 0, 9, 1, 0, 0, 0);
    push("b_pre_rst", K_ST, 1, 1, 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push("b_post_rst", K_ST, 1, 0, 0);
    push("b_post_rst", K_R1, 1, RS1, 0);
    push("b_post_rst_cnt", K_CNT, 1, 0, 0);
    push("a_post_rst_cnt", K_CNT, 0, 0, 0);
    tick();
    drive_b(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();

    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
